mul_booth_seq: RTL and testbench

Multi-cycle signed 32×32→64 multiplier controller for the CPU datapath. It latches two operands on a `start` handshake and runs 16 radix-4 Booth (bit-pair) iterations, one per clock, over a single shared recoder/adder. It then writes the 64-bit product into its HI/LO result registers. It replaces the single-cycle combinational multiplier on the ALU MUL path when timing closure requires it; the control unit stalls on `busy` and captures on `done`.

---
 rtl/mul_booth_seq_pkg.sv | 34 +++
 rtl/mul_booth_seq_if.sv | 32 +++
 rtl/mul_booth_seq_recode.sv | 38 +++
 rtl/mul_booth_seq.sv | 110 +++++++++++
 tb/tb_mul_booth_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mul_booth_seq_pkg.sv
// Shared multiplier/divider definitions.
//   mul_state_e   : controller state encoding (IDLE, RUN, DONE), 2-bit binary.
//   booth_digit_e : radix-4 Booth digit codes. Bit 2 is the sign, and bits 1:0
//                   hold the magnitude (0, 1 or 2). The divider controller reuses them.
//   booth_digit() : maps a 3-bit overlapping multiplier group to its digit.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   typedef enum logic [2:0] {
      ZERO = 3'b000,
      POS1 = 3'b001,
      POS2 = 3'b010,
      NEG1 = 3'b101,
      NEG2 = 3'b110
   } booth_digit_e;

   function automatic booth_digit_e booth_digit(input logic [2:0] group);
      booth_digit_e d;
      case (group)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;   // 000 and 111
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mul_booth_seq_if.sv
// Request/result bundle between the control unit and the sequential multiplier.
//   start  : request a multiply; only looked at while the multiplier is idle.
//   M, Q   : multiplicand / multiplier, two's complement, latched on accept.
//   busy   : operation in progress.
//   done   : one-cycle completion pulse; hi/lo are valid from this cycle on.
//   hi, lo : upper / lower halves of the 2*WIDTH product, held between completions.
// Handshake: a request is accepted on the rising edge where start=1 and busy=0
// and the multiplier is idle. No back-pressure exists; the requester watches busy
// and captures hi/lo on done. Requests presented outside IDLE are dropped.
interface mul_booth_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] Q;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // Control unit side.
   modport master (
      output start, M, Q,
      input  busy, done, hi, lo
   );

   // Multiplier side.
   modport slave (
      input  start, M, Q,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_booth_seq_recode.sv
// booth_recode_r4: combinational radix-4 Booth partial-product generator.
//   group_i : {Qr[2k+1], Qr[2k], Qr[2k-1]} overlapping multiplier bits.
//   mr_i    : latched multiplicand, two's complement.
//   pp_o    : digit * mr_i, two's complement at WIDTH+2 bits. Two extra bits
//             cover both +/-2*mr_i and the negation of the most negative operand.
module booth_recode_r4
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       group_i,
   input  logic [WIDTH-1:0] mr_i,
   output logic [WIDTH+1:0] pp_o
);

   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;
   logic [WIDTH+1:0] mag;
   logic             neg;

   assign m1 = {{2{mr_i[WIDTH-1]}}, mr_i};
   assign m2 = {m1[WIDTH:0], 1'b0};

   always_comb begin
      mag = '0;
      neg = 1'b0;
      case (booth_digit(group_i))
         POS1:    mag = m1;
         POS2:    mag = m2;
         NEG1:    begin mag = m1; neg = 1'b1; end
         NEG2:    begin mag = m2; neg = 1'b1; end
         default: mag = '0;
      endcase
      // Negate unit: two's complement at the full WIDTH+2 width.
      pp_o = neg ? (~mag + (WIDTH+2)'(1)) : mag;
   end

endmodule

// File: rtl/mul_booth_seq.sv
// mul_booth_seq: multi-cycle signed WIDTH x WIDTH -> 2*WIDTH multiplier.
// The block runs one radix-4 Booth step per clock over a shared recoder and adder.
//   clock       : rising-edge clock.
//   clear_n     : synchronous active-low reset. It discards any operation in flight.
//   bus         : mul_booth_seq_if.slave (start/M/Q in, busy/done/hi/lo out).
//   dbg_state_o : current FSM state, for observation only.
// Timing: accept at edge E0, and edges E1..E(W/2) process bit pairs 0..W/2-1.
// At E(W/2), hi/lo load, done rises and busy falls. One edge later the FSM is back in IDLE.
module mul_booth_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clock,
   input  logic       clear_n,
   mul_booth_seq_if.slave bus,
   output mul_state_e dbg_state_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH / 2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

   mul_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mr_q;
   logic [WIDTH-1:0] qr_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    acc_d;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH:0]   q_ext;
   logic [2:0]       group;
   logic [WIDTH+1:0] pp;
   logic [PW-1:0]    pp_shift;

   // Qr[-1] = 0 is provided by the appended zero. Group k therefore starts at bit 2k of q_ext.
   assign q_ext = {qr_q, 1'b0};
   assign group = q_ext[{cnt_q, 1'b0} +: 3];

   booth_recode_r4 #(.WIDTH(WIDTH)) u_recode (
      .group_i (group),
      .mr_i    (mr_q),
      .pp_o    (pp)
   );

   // Sign-extend the partial product to the product width and align it to bit 2*cnt.
   // The sum wraps modulo 2^PW, which is exact because the true product fits.
   assign pp_shift = {{(PW - WIDTH - 2){pp[WIDTH+1]}}, pp} << {cnt_q, 1'b0};
   assign acc_d    = acc_q + pp_shift;

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mr_q    <= '0;
         qr_q    <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mr_q    <= bus.M;
                  qr_q    <= bus.Q;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  hi_q    <= acc_d[PW-1:WIDTH];
                  lo_q    <= acc_d[WIDTH-1:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // A start seen here is dropped. The requester must present it again in IDLE.
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Directed bench for mul_booth_seq. Inputs are driven and outputs are sampled on the
// falling clock edge, and expected products come from a 64-bit longint multiply.
module tb_mul_booth_seq;
   import mul_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic clear_n;
   always #5 clock = ~clock;

   mul_booth_seq_if #(.WIDTH(W)) bus ();
   mul_state_e dbg_state;

   mul_booth_seq #(.WIDTH(W)) dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [63:0] prev_res = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint x;
      longint y;
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
   endfunction

   // ---------------- driver tasks ----------------
   // Call this just after the accepting edge. It returns the number of edges until
   // done is seen and checks that hi/lo hold the previous result meanwhile.
   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (!bus.done && lat < 40) begin
         chk({tag, "_hold"}, {bus.hi, bus.lo}, prev_res);
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run_op(input logic [31:0] m, input logic [31:0] q, input string tag);
      logic [63:0] exp;
      int          lat;
      exp       = ref_mul(m, q);
      bus.M     = m;
      bus.Q     = q;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      bus.M     = $urandom;   // operands after accept must not matter
      bus.Q     = $urandom;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      wait_done(tag, lat);
      chk({tag, "_latency"}, 64'(lat), 64'd16);
      chk({tag, "_product"}, {bus.hi, bus.lo}, exp);
      chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      @(negedge clock);
      chk({tag, "_done_width"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle"}, 64'(dbg_state), 64'(IDLE));
      prev_res = exp;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int k;
      int seen;

      bus.start = 1'b0;
      bus.M     = '0;
      bus.Q     = '0;
      clear_n   = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("reset_state", 64'(dbg_state), 64'(IDLE));
      clear_n = 1'b1;
      @(negedge clock);

      run_op(32'd7, 32'd3, "m7x3");
      chk("m7x3_lo_const", 64'(bus.lo), 64'h15);
      run_op(32'hFFFF_FFFB, 32'd6, "neg5x6");
      chk("neg5x6_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFE2);
      run_op(32'h8000_0000, 32'h8000_0000, "minxmin");
      chk("minxmin_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
      run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxxmax");
      chk("maxxmax_const", {bus.hi, bus.lo}, 64'h3FFF_FFFF_0000_0001);
      run_op(32'h8000_0000, 32'h7FFF_FFFF, "minxmax");
      run_op(32'd0, 32'h8000_0000, "zeroxmin");

      // start held high across a whole operation, with operands changed during RUN
      bus.M     = '1;
      bus.Q     = '1;
      bus.start = 1'b1;
      @(negedge clock);
      bus.M = 32'd2;
      bus.Q = 32'd3;
      chk("held_busy", 64'(bus.busy), 64'd1);
      wait_done("held1", lat);
      chk("held1_latency", 64'(lat), 64'd16);
      chk("held1_product", {bus.hi, bus.lo}, 64'd1);
      prev_res = 64'd1;
      @(negedge clock);
      chk("held1_done_width", 64'(bus.done), 64'd0);
      k = 0;
      while (!bus.busy && k < 3) begin
         @(negedge clock);
         k++;
      end
      chk("held2_accept", 64'(bus.busy), 64'd1);
      wait_done("held2", lat);
      bus.start = 1'b0;
      chk("held2_latency", 64'(lat), 64'd16);
      chk("held2_product", {bus.hi, bus.lo}, 64'd6);
      @(negedge clock);
      chk("held2_done_width", 64'(bus.done), 64'd0);
      prev_res = 64'd6;

      // synchronous clear in the middle of RUN (cnt = 7)
      bus.M     = 32'd1000;
      bus.Q     = 32'd1000;
      bus.start = 1'b1;
      @(negedge clock);                 // E0 passed
      bus.start = 1'b0;
      repeat (7) @(negedge clock);      // E1..E7 done, cnt = 7
      clear_n = 1'b0;
      @(negedge clock);
      clear_n = 1'b1;
      chk("clr_busy", 64'(bus.busy), 64'd0);
      chk("clr_done", 64'(bus.done), 64'd0);
      chk("clr_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("clr_state", 64'(dbg_state), 64'(IDLE));
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.done) seen++;
      end
      chk("clr_no_done", 64'(seen), 64'd0);
      prev_res = 64'd0;
      run_op(32'd1000, 32'd1000, "after_clr");
      chk("after_clr_const", 64'(bus.lo), 64'h000F_4240);

      // compact signed sweep against the longint reference
      for (int i = 0; i < 150; i++) begin
         run_op($urandom, $urandom, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
